bot_request_responder: RTL and testbench

Buffered producer that answers the `requestGraph` pull handshake of a compute module. It accepts bot/extra-data pairs from an upstream valid/ready stream into a FIFO and, for every request, delivers the head entry with `start` high exactly `REQUEST_LATENCY` cycles later. If the FIFO is empty it delivers a bubble (`start` low) in that slot instead. It sits between the job distributor and each compute module, one instance per module.

---
 rtl/bot_request_responder_pkg.sv | 14 +
 rtl/bot_request_responder_job_fifo.sv | 56 +++++
 rtl/bot_request_responder.sv | 94 +++++++++
 tb/tb_bot_request_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bot_request_responder_pkg.sv
// Shared widths and the job slot carried from the dispatcher to the compute modules.
package bot_request_responder_pkg;

  localparam int BOT_WIDTH       = 128;
  localparam int COUNT_WIDTH     = 32;
  localparam int JOB_EXTRA_WIDTH = 14;

  typedef struct packed {
    logic                       start;
    logic [BOT_WIDTH-1:0]       bot;
    logic [JOB_EXTRA_WIDTH-1:0] extraData;
  } job_slot_t;

endpackage

// File: rtl/bot_request_responder_job_fifo.sv
// Single-clock FIFO with registered read; storage is unreset so it can map to block RAM.
module job_fifo #(
  parameter int WIDTH = 142,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; the fill count is kept one bit wider to tell full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bot_request_responder.sv
// Answers requestGraph pulls from the FIFO head, exactly REQUEST_LATENCY cycles later.
module bot_request_responder
  import bot_request_responder_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH = JOB_EXTRA_WIDTH,
  parameter int REQUEST_LATENCY  = 3,
  parameter int DEPTH            = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [BOT_WIDTH-1:0]          inBot,
  input  logic [EXTRA_DATA_WIDTH-1:0]   inExtraData,
  input  logic                          requestGraph,
  output logic [BOT_WIDTH-1:0]          botOut,
  output logic                          start,
  output logic [EXTRA_DATA_WIDTH-1:0]   extraDataOut,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic [COUNT_WIDTH-1:0]        issuedCount,
  output logic [COUNT_WIDTH-1:0]        bubbleCount
);

  localparam int FW = BOT_WIDTH + EXTRA_DATA_WIDTH;

  typedef struct packed {
    logic                        start;
    logic [BOT_WIDTH-1:0]        bot;
    logic [EXTRA_DATA_WIDTH-1:0] extraData;
  } slot_t;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rd_data;
  logic          head_valid;
  slot_t         head_slot;
  slot_t         pipe [1:REQUEST_LATENCY-1];
  logic          last_in_start;

  assign inReady   = !fifo_full;
  assign fifo_push = inValid && !fifo_full;
  assign fifo_pop  = requestGraph && !fifo_empty;

  job_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({inBot, inExtraData}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  // The FIFO read register is the first pipe stage; bubbles are zeroed here once.
  always_comb begin
    head_slot = '0;
    if (head_valid) head_slot = {1'b1, fifo_rd_data};
  end

  generate
    if (REQUEST_LATENCY == 2) begin : g_short
      assign last_in_start = head_slot.start;
    end else begin : g_long
      assign last_in_start = pipe[REQUEST_LATENCY-2].start;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid  <= 1'b0;
      issuedCount <= '0;
      bubbleCount <= '0;
      for (int i = 1; i < REQUEST_LATENCY; i++) pipe[i] <= '0;
    end else begin
      head_valid <= fifo_pop;
      pipe[1]    <= head_slot;
      for (int i = 2; i < REQUEST_LATENCY; i++) pipe[i] <= pipe[i-1];
      if (requestGraph && fifo_empty) bubbleCount <= bubbleCount + 1'b1;
      if (last_in_start) issuedCount <= issuedCount + 1'b1;
    end
  end

  assign start        = pipe[REQUEST_LATENCY-1].start;
  assign botOut       = pipe[REQUEST_LATENCY-1].bot;
  assign extraDataOut = pipe[REQUEST_LATENCY-1].extraData;

endmodule

// File: tb/tb_bot_request_responder.sv
// Directed bench for bot_request_responder with DEPTH=4 and REQUEST_LATENCY=3.
module tb_bot_request_responder;

  localparam int EW = 14;
  localparam int LAT = 3;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [127:0]  inBot;
  logic [EW-1:0] inExtraData;
  logic          requestGraph;
  logic [127:0]  botOut;
  logic          start;
  logic [EW-1:0] extraDataOut;
  logic [2:0]    occupancy;
  logic [31:0]   issuedCount;
  logic [31:0]   bubbleCount;

  int checks = 0;
  int errors = 0;
  int runLen = 0;
  int maxRun = 0;
  logic [127+EW:0] expQ [$];

  bot_request_responder #(
    .EXTRA_DATA_WIDTH (EW),
    .REQUEST_LATENCY  (LAT),
    .DEPTH            (DEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inValid      (inValid),
    .inReady      (inReady),
    .inBot        (inBot),
    .inExtraData  (inExtraData),
    .requestGraph (requestGraph),
    .botOut       (botOut),
    .start        (start),
    .extraDataOut (extraDataOut),
    .occupancy    (occupancy),
    .issuedCount  (issuedCount),
    .bubbleCount  (bubbleCount)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] patBot(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hA5C3_0000;
    return {w, ~w, w + 32'h0101_0101, w};
  endfunction

  function automatic logic [EW-1:0] patEx(input int i);
    return EW'(i * 3 + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] b, input logic [EW-1:0] e, input logic req);
    inValid      = v;
    inBot        = b;
    inExtraData  = e;
    requestGraph = req;
  endtask

  // One clock: record accepted pushes, then check every delivered slot against the push order.
  task automatic step();
    if (inValid && inReady && rst) expQ.push_back({inBot, inExtraData});
    @(posedge clk);
    #1;
    if (start) begin
      runLen++;
      if (runLen > maxRun) maxRun = runLen;
      if (expQ.size() == 0) checkOutput("unexpected_start", 160'(start), 160'(0));
      else checkOutput("delivered_job", 160'({botOut, extraDataOut}), 160'(expQ.pop_front()));
    end else begin
      runLen = 0;
      checkOutput("bubble_zero", 160'({botOut, extraDataOut}), 160'(0));
    end
  endtask

  initial begin
    int nextIdx;
    int seq;
    logic willPush;

    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    step();
    step();
    checkOutput("reset_start", 160'(start), 160'(0));
    checkOutput("reset_bot", 160'(botOut), 160'(0));
    checkOutput("reset_extra", 160'(extraDataOut), 160'(0));
    checkOutput("reset_occupancy", 160'(occupancy), 160'(0));
    checkOutput("reset_issued", 160'(issuedCount), 160'(0));
    checkOutput("reset_bubble", 160'(bubbleCount), 160'(0));
    rst = 1'b1;
    #1;
    checkOutput("ready_after_reset", 160'(inReady), 160'(1));
    step();

    $display("[TB] empty request");
    applyStimulus(1'b0, '0, '0, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("empty_bubble_count", 160'(bubbleCount), 160'(1));
    step();
    step();
    checkOutput("empty_start", 160'(start), 160'(0));
    checkOutput("empty_bot", 160'(botOut), 160'(0));
    step();

    $display("[TB] latency");
    applyStimulus(1'b1, {16{8'hA5}}, 14'h12, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("push_occupancy", 160'(occupancy), 160'(1));
    step();
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("pop_occupancy", 160'(occupancy), 160'(0));
    step();
    checkOutput("latency_early", 160'(start), 160'(0));
    step();
    checkOutput("latency_start", 160'(start), 160'(1));
    checkOutput("latency_bot", 160'(botOut), 160'({16{8'hA5}}));
    checkOutput("latency_extra", 160'(extraDataOut), 160'(14'h12));
    checkOutput("latency_issued", 160'(issuedCount), 160'(1));
    step();
    checkOutput("latency_single", 160'(start), 160'(0));

    $display("[TB] same-cycle push and request");
    applyStimulus(1'b1, patBot(7), patEx(7), 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    step();
    checkOutput("nobypass_bubble", 160'(start), 160'(0));
    checkOutput("nobypass_bubble_count", 160'(bubbleCount), 160'(2));
    step();
    checkOutput("nobypass_next_start", 160'(start), 160'(1));
    checkOutput("nobypass_next_bot", 160'(botOut), 160'(patBot(7)));
    step();

    $display("[TB] full and wrap");
    nextIdx = 100;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, patBot(nextIdx), patEx(nextIdx), 1'b0);
      willPush = inReady;
      step();
      if (willPush) nextIdx++;
      if (c == 3) begin
        checkOutput("full_ready_low", 160'(inReady), 160'(0));
        checkOutput("full_occupancy", 160'(occupancy), 160'(4));
      end
    end
    checkOutput("full_stalled", 160'(nextIdx), 160'(104));
    for (int c = 0; c < 10; c++) begin
      applyStimulus(nextIdx < 106, patBot(nextIdx), patEx(nextIdx), 1'b1);
      willPush = inValid && inReady;
      step();
      if (willPush) nextIdx++;
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 3; c++) step();
    checkOutput("wrap_all_out", 160'(expQ.size()), 160'(0));
    checkOutput("wrap_issued", 160'(issuedCount), 160'(8));
    checkOutput("wrap_bubble", 160'(bubbleCount), 160'(6));
    checkOutput("wrap_occupancy", 160'(occupancy), 160'(0));

    $display("[TB] streaming");
    seq = 200;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, patBot(seq), patEx(seq), 1'b0);
      step();
      seq++;
    end
    maxRun = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, patBot(seq), patEx(seq), 1'b1);
      willPush = inReady;
      step();
      if (willPush) seq++;
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 3; c++) step();
    checkOutput("stream_run", 160'(maxRun), 160'(100));
    checkOutput("stream_issued", 160'(issuedCount), 160'(108));
    checkOutput("stream_bubble", 160'(bubbleCount), 160'(6));
    checkOutput("stream_occupancy", 160'(occupancy), 160'(2));

    $display("[TB] reset mid-flight");
    applyStimulus(1'b0, '0, '0, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    expQ.delete();
    step();
    step();
    checkOutput("midreset_start", 160'(start), 160'(0));
    checkOutput("midreset_occupancy", 160'(occupancy), 160'(0));
    checkOutput("midreset_issued", 160'(issuedCount), 160'(0));
    checkOutput("midreset_bubble", 160'(bubbleCount), 160'(0));
    rst = 1'b1;
    #1;
    checkOutput("midreset_ready", 160'(inReady), 160'(1));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
